// File: rtl/result_capture_pkg.sv
// Shared types and helpers for the result capture stage.
// The signature helper is shared by the RTL and its bench model.
package result_capture_pkg;

   localparam int DATA_W_DEF = 24;
   localparam int DEPTH_DEF  = 8;
   localparam int CNT_W_DEF  = 16;

   typedef logic [23:0] result_t;

   // Rotate left by one, then fold in the pushed word.
   function automatic result_t sig_next(result_t sig, result_t d);
      return {sig[22:0], sig[23]} ^ d;
   endfunction

endpackage

// File: rtl/capture_ram.sv
// DEPTH x DATA_W storage: one write port, one asynchronous read port.
// Contents are deliberately left unreset.
module capture_ram #(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/result_capture_fifo.sv
// First-word-fall-through capture FIFO with saturating push counter.
// Optional push signature port when CAPTURE_SIGNATURE_EN is defined.
module result_capture_fifo
   import result_capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         accepted_cnt
`ifdef CAPTURE_SIGNATURE_EN
   ,
   output logic [DATA_W-1:0]        sig
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] rd_data;

   // Extra MSB distinguishes full from empty when low bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_ptr[AW] != rd_ptr[AW]);

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign out_data  = out_valid ? rd_data : '0;
   assign level     = wr_ptr - rd_ptr;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   capture_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (in_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
      end else if (pop) begin
         rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Holds at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accepted_cnt <= '0;
      end else if (push && (accepted_cnt != '1)) begin
         accepted_cnt <= accepted_cnt + CNT_W'(1);
      end
   end

`ifdef CAPTURE_SIGNATURE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= '0;
      end else if (push) begin
         sig <= sig_next(sig, in_data);
      end
   end
`endif

endmodule

// File: tb/tb_result_capture_fifo.sv
// Randomised and directed bench for result_capture_fifo against a queue model.
// Signature checks are compiled in when CAPTURE_SIGNATURE_EN is defined.
module tb_result_capture_fifo;
   import result_capture_pkg::*;

   localparam int DW = 24;
   localparam int DP = 8;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          out_ready;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [3:0]    level;
   logic [15:0]   accepted_cnt;
   logic          in_ready4;
   logic          out_valid4;
   logic [DW-1:0] out_data4;
   logic [3:0]    level4;
   logic [3:0]    accepted_cnt4;
`ifdef CAPTURE_SIGNATURE_EN
   logic [DW-1:0] sig;
   logic [DW-1:0] sig4;
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] q[$];
   int            n_push;
   logic [DW-1:0] msig;

   result_capture_fifo dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .level        (level),
      .accepted_cnt (accepted_cnt)
`ifdef CAPTURE_SIGNATURE_EN
      ,
      .sig          (sig)
`endif
   );

   result_capture_fifo #(.CNT_W(4)) dut4 (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready4),
      .in_data      (in_data),
      .out_valid    (out_valid4),
      .out_ready    (out_ready),
      .out_data     (out_data4),
      .level        (level4),
      .accepted_cnt (accepted_cnt4)
`ifdef CAPTURE_SIGNATURE_EN
      ,
      .sig          (sig4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int n, input int mx);
      return (n > mx) ? mx : n;
   endfunction

   // Compare against the model, then predict the effect of the coming edge.
   always @(negedge clk) begin
      automatic bit do_push;
      automatic bit do_pop;
      if (!rst_n) begin
         q.delete();
         n_push = 0;
         msig   = '0;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_level", level, 0);
      end else begin
         chk("m_out_valid", out_valid, q.size() > 0);
         chk("m_out_data", out_data, (q.size() > 0) ? q[0] : 0);
         chk("m_in_ready", in_ready, q.size() < DP);
         chk("m_level", level, q.size());
         chk("m_cnt", accepted_cnt, sat(n_push, 65535));
         chk("m_cnt4", accepted_cnt4, sat(n_push, 15));
         chk("m_out_data4", out_data4, (q.size() > 0) ? q[0] : 0);
         chk("m_level4", level4, q.size());
         chk("m_in_ready4", in_ready4, q.size() < DP);
         chk("m_out_valid4", out_valid4, q.size() > 0);
`ifdef CAPTURE_SIGNATURE_EN
         chk("m_sig", sig, msig);
         chk("m_sig4", sig4, msig);
`endif
         do_push = in_valid && (q.size() < DP);
         do_pop  = out_ready && (q.size() > 0);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            q.push_back(in_data);
            n_push++;
            msig = sig_next(msig, in_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      chk("pin_sig_a", sig_next(24'h000000, 24'h000001), 24'h000001);
      chk("pin_sig_b", sig_next(24'h000001, 24'h000003), 24'h000001);
      chk("pin_sig_c", sig_next(24'h800000, 24'h000000), 24'h000001);

      #1;
      chk("t0_in_ready", in_ready, 1);
      chk("t0_out_valid", out_valid, 0);
      chk("t0_out_data", out_data, 0);
      chk("t0_cnt", accepted_cnt, 0);
      do_reset();

      // Test 1: three pushes, no pops.
      in_valid = 1'b1;
      in_data  = 24'h000001;
      chk("t1_pre_valid", out_valid, 0);
      tick();
      chk("t1_first_valid", out_valid, 1);
      chk("t1_first_data", out_data, 24'h000001);
      in_data = 24'h000002;
      tick();
      in_data = 24'hFFFFFF;
      tick();
      in_valid = 1'b0;
      chk("t1_level", level, 3);
      chk("t1_cnt", accepted_cnt, 3);
      chk("t1_data", out_data, 24'h000001);
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      chk("t1_drained", out_valid, 0);

      // Test 2: fill to full, held word waits for space.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 24'h10 + 24'(i);
         tick();
      end
      in_data = 24'h18;
      chk("t2_full_level", level, 8);
      chk("t2_full_ready", in_ready, 0);
      tick();
      chk("t2_held_level", level, 8);
      chk("t2_held_data", out_data, 24'h10);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t2_pop_level", level, 7);
      chk("t2_pop_ready", in_ready, 1);
      chk("t2_pop_data", out_data, 24'h11);
      tick();
      in_valid = 1'b0;
      chk("t2_refill", level, 8);
      out_ready = 1'b1;
      repeat (8) tick();
      out_ready = 1'b0;
      chk("t2_drained", level, 0);

      // Test 3: steady state at level 4 with pointer wrap.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 24'h100 + 24'(i);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 24'h200 + 24'(i);
         tick();
         chk("t3_level", level, 4);
      end
      in_valid = 1'b0;
      repeat (4) tick();
      out_ready = 1'b0;
      chk("t3_drained", level, 0);

      // Test 4: no bypass through an empty FIFO.
      in_valid  = 1'b1;
      in_data   = 24'h0000AA;
      out_ready = 1'b1;
      chk("t4_push_cycle", out_valid, 0);
      tick();
      in_valid = 1'b0;
      chk("t4_visible", out_valid, 1);
      chk("t4_data", out_data, 24'h0000AA);
      tick();
      out_ready = 1'b0;
      chk("t4_level", level, 0);
      chk("t4_empty", out_valid, 0);

      // Test 5: asynchronous reset between edges.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 24'h300 + 24'(i);
         tick();
      end
      in_valid = 1'b0;
      chk("t5_level5", level, 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_level", level, 0);
      chk("t5_valid", out_valid, 0);
      chk("t5_data", out_data, 0);
      chk("t5_cnt", accepted_cnt, 0);
      chk("t5_ready", in_ready, 1);
      tick();
      rst_n = 1'b1;

`ifdef CAPTURE_SIGNATURE_EN
      // Test 6: signature accumulates on pushes only.
      in_valid = 1'b1;
      in_data  = 24'h000001;
      tick();
      chk("t6_sig1", sig, 24'h000001);
      in_data = 24'h000003;
      tick();
      in_valid = 1'b0;
      chk("t6_sig2", sig, 24'h000001);
      out_ready = 1'b1;
      repeat (2) tick();
      out_ready = 1'b0;
      chk("t6_sig_pop", sig, 24'h000001);
      do_reset();
`endif

      // Narrow counter saturates after 17 pushes.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_data = 24'h400 + 24'(i);
         tick();
      end
      in_valid = 1'b0;
      chk("t5_cnt4_sat", accepted_cnt4, 15);
      chk("t5_cnt17", accepted_cnt, 17);
      tick();
      out_ready = 1'b0;

      // Random traffic with shifting bias to visit full and empty.
      for (int i = 0; i < 2400; i++) begin
         case ((i / 300) % 3)
            0: begin
               in_valid  = ($urandom_range(0, 3) != 0);
               out_ready = ($urandom_range(0, 3) == 0);
            end
            1: begin
               in_valid  = ($urandom_range(0, 3) == 0);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            default: begin
               in_valid  = $urandom_range(0, 1) == 1;
               out_ready = $urandom_range(0, 1) == 1;
            end
         endcase
         in_data = 24'($urandom);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) tick();
      out_ready = 1'b0;
      tick();
      chk("end_empty", level, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
